// File: rtl/mem_loader.sv
// mem_loader: byte-stream loader for the MIPS instruction/data memories.
//   Accepts framed bytes (TARGET, COUNT_HI, COUNT_LO, 4*N payload bytes) and
//   issues big-endian 32-bit word writes starting at address 0. The CPU is
//   held stalled while a frame is in flight.
// Ports: clk/rst (async active-high), in_valid/in_data/in_ready byte input,
//   mem_we/mem_sel/mem_addr/mem_wdata word write port (sel 0 = IM, 1 = DM),
//   cpu_hold stall request, done (last frame complete), err (sticky).
// Optional: define MEM_LOADER_CHKSUM_EN to require a trailing XOR checksum
//   byte after the payload.
module mem_loader #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_HI,
    S_CNT_LO,
    S_DATA,
    S_WRITE,
`ifdef MEM_LOADER_CHKSUM_EN
    S_CHK,
`endif
    S_DONE
  } state_t;

  state_t           state;
  logic [7:0]       cnt_hi;
  logic [CNT_W-1:0] remaining;
  logic [1:0]       byte_idx;
  // One extra MSB marks "address ran past the end of memory"; it never wraps
  // because the increment stops once it is set.
  logic [ADDR_W:0]  addr;
`ifdef MEM_LOADER_CHKSUM_EN
  logic [7:0]       chk;
`endif

  logic take;
  assign take     = in_valid && in_ready;
  assign mem_addr = addr[ADDR_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_sel   <= 1'b0;
      mem_wdata <= 32'h0;
      cpu_hold  <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      cnt_hi    <= 8'h0;
      remaining <= '0;
      byte_idx  <= 2'd0;
      addr      <= '0;
`ifdef MEM_LOADER_CHKSUM_EN
      chk       <= 8'h0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        S_IDLE: begin
          // in_ready is registered, so it first rises one cycle after reset.
          in_ready <= 1'b1;
          if (take) begin
            if (in_data == 8'h00 || in_data == 8'h01) begin
              mem_sel  <= in_data[0];
              cpu_hold <= 1'b1;
              done     <= 1'b0;
              state    <= S_CNT_HI;
`ifdef MEM_LOADER_CHKSUM_EN
              chk      <= 8'h0;
`endif
            end else begin
              err <= 1'b1;
            end
          end
        end

        S_CNT_HI: begin
          if (take) begin
            cnt_hi <= in_data;
            state  <= S_CNT_LO;
          end
        end

        S_CNT_LO: begin
          if (take) begin
            addr     <= '0;
            byte_idx <= 2'd0;
            if ({cnt_hi, in_data} == 16'h0000) begin
`ifdef MEM_LOADER_CHKSUM_EN
              state    <= S_CHK;
`else
              state    <= S_DONE;
              in_ready <= 1'b0;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
`endif
            end else begin
              remaining <= {cnt_hi, in_data};
              state     <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (take) begin
            mem_wdata <= {mem_wdata[23:0], in_data};
            byte_idx  <= byte_idx + 2'd1;
`ifdef MEM_LOADER_CHKSUM_EN
            chk       <= chk ^ in_data;
`endif
            if (byte_idx == 2'd3) begin
              state    <= S_WRITE;
              in_ready <= 1'b0;
              // Past the end of memory: swallow the word, flag it, no write.
              if (addr[ADDR_W]) begin
                err <= 1'b1;
              end else begin
                mem_we <= 1'b1;
              end
            end
          end
        end

        S_WRITE: begin
          remaining <= remaining - CNT_W'(1);
          if (!addr[ADDR_W]) begin
            addr <= addr + (ADDR_W+1)'(4);
          end
          if (remaining == CNT_W'(1)) begin
`ifdef MEM_LOADER_CHKSUM_EN
            state    <= S_CHK;
            in_ready <= 1'b1;
`else
            state    <= S_DONE;
            in_ready <= 1'b0;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
`endif
          end else begin
            state    <= S_DATA;
            in_ready <= 1'b1;
          end
        end

`ifdef MEM_LOADER_CHKSUM_EN
        S_CHK: begin
          if (take) begin
            if (in_data != chk) begin
              err <= 1'b1;
            end
            state    <= S_DONE;
            in_ready <= 1'b0;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end
        end
`endif

        S_DONE: begin
          // done/cpu_hold keep their values until the next valid TARGET.
          state    <= S_IDLE;
          in_ready <= 1'b1;
        end

        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
module tb_mem_loader;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          mem_we;
  logic          mem_sel;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_hold;
  logic          done;
  logic          err;

  int checks = 0;
  int passes = 0;
  int wcount = 0;
  logic [7:0] pay_xor;

  mem_loader #(.ADDR_W(AW), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_sel(mem_sel),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mem_we === 1'b1) wcount++;

  // Present a byte from a falling edge and hold it until it is accepted;
  // returns 1ns after the accepting rising edge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      $display("FAIL handshake: in_ready=%b want 1 within 50 cycles", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_pay(input logic [7:0] b);
    pay_xor = pay_xor ^ b;
    send_byte(b);
  endtask

  task automatic send_word(input logic [31:0] w);
    send_pay(w[31:24]);
    send_pay(w[23:16]);
    send_pay(w[15:8]);
    send_pay(w[7:0]);
  endtask

  task automatic send_trailer();
`ifdef MEM_LOADER_CHKSUM_EN
    send_byte(pay_xor);
`endif
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1) $display("FAIL %s_done: done=%b want 1", tag, done);
    else passes++;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({cpu_hold, in_ready, done, err, mem_we} !== 5'b10000)
      $display("FAIL reset_outs: hold,rdy,done,err,we=%b want 10000",
               {cpu_hold, in_ready, done, err, mem_we});
    else passes++;
    checks++;
    if ({mem_sel, mem_addr, mem_wdata} !== 37'h0)
      $display("FAIL reset_port: sel/addr/wdata=%h want 0", {mem_sel, mem_addr, mem_wdata});
    else passes++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) $display("FAIL rdy_at_release: in_ready=%b want 0", in_ready);
    else passes++;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) $display("FAIL rdy_after_release: in_ready=%b want 1", in_ready);
    else passes++;
  endtask

  task automatic test_im_load();
    int w0;
    w0 = wcount;
    pay_xor = 8'h00;
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h02);
    checks++;
    if (cpu_hold !== 1'b1) $display("FAIL im_hold: cpu_hold=%b want 1", cpu_hold);
    else passes++;
    send_word(32'h20080005);
    checks++;
    if ({mem_we, mem_sel, mem_addr, mem_wdata} !== {1'b1, 1'b0, 4'h0, 32'h20080005})
      $display("FAIL im_w0: we,sel,addr,data=%h want %h",
               {mem_we, mem_sel, mem_addr, mem_wdata}, {1'b1, 1'b0, 4'h0, 32'h20080005});
    else passes++;
    send_word(32'h2009000A);
    checks++;
    if ({mem_we, mem_sel, mem_addr, mem_wdata} !== {1'b1, 1'b0, 4'h4, 32'h2009000A})
      $display("FAIL im_w1: we,sel,addr,data=%h want %h",
               {mem_we, mem_sel, mem_addr, mem_wdata}, {1'b1, 1'b0, 4'h4, 32'h2009000A});
    else passes++;
    send_trailer();
    wait_done("im");
    checks++;
    if ({cpu_hold, err} !== 2'b00) $display("FAIL im_flags: hold,err=%b want 00", {cpu_hold, err});
    else passes++;
    checks++;
    if (wcount - w0 !== 2) $display("FAIL im_wcount: writes=%0d want 2", wcount - w0);
    else passes++;
  endtask

  task automatic test_dm_stall();
    int w0;
    int gap_we;
    w0 = wcount;
    gap_we = 0;
    pay_xor = 8'h00;
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h01);
    send_pay(8'hDE); send_pay(8'hAD);
    repeat (7) begin
      @(negedge clk);
      if (mem_we !== 1'b0) gap_we++;
    end
    checks++;
    if (gap_we !== 0 || wcount != w0)
      $display("FAIL dm_gap: writes in gap=%0d want 0", gap_we + wcount - w0);
    else passes++;
    send_pay(8'hBE); send_pay(8'hEF);
    checks++;
    if ({mem_we, mem_sel, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'h0, 32'hDEADBEEF})
      $display("FAIL dm_w0: we,sel,addr,data=%h want %h",
               {mem_we, mem_sel, mem_addr, mem_wdata}, {1'b1, 1'b1, 4'h0, 32'hDEADBEEF});
    else passes++;
    send_trailer();
    wait_done("dm");
    checks++;
    if (wcount - w0 !== 1) $display("FAIL dm_wcount: writes=%0d want 1", wcount - w0);
    else passes++;
  endtask

  task automatic test_bad_target_empty();
    int w0;
    w0 = wcount;
    pay_xor = 8'h00;
    send_byte(8'h05);
    @(negedge clk);
    checks++;
    if ({err, in_ready, done} !== 3'b111)
      $display("FAIL bad_target: err,rdy,done=%b want 111", {err, in_ready, done});
    else passes++;
    send_byte(8'h00);
    checks++;
    if ({done, cpu_hold} !== 2'b01)
      $display("FAIL empty_start: done,hold=%b want 01", {done, cpu_hold});
    else passes++;
    send_byte(8'h00); send_byte(8'h00);
    send_trailer();
    wait_done("empty");
    checks++;
    if (wcount != w0 || cpu_hold !== 1'b0)
      $display("FAIL empty_result: writes=%0d hold=%b want 0 0", wcount - w0, cpu_hold);
    else passes++;
  endtask

  task automatic test_overflow();
    logic [31:0] ws [5];
    int w0;
    ws[0] = 32'h01020304; ws[1] = 32'h05060708; ws[2] = 32'h090A0B0C;
    ws[3] = 32'h0D0E0F10; ws[4] = 32'h11121314;
    pulse_reset();
    w0 = wcount;
    pay_xor = 8'h00;
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h05);
    for (int i = 0; i < 4; i++) begin
      send_word(ws[i]);
      checks++;
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 4'(i * 4), ws[i]})
        $display("FAIL ovf_w%0d: we,addr,data=%h want %h", i,
                 {mem_we, mem_addr, mem_wdata}, {1'b1, 4'(i * 4), ws[i]});
      else passes++;
    end
    checks++;
    if (err !== 1'b0) $display("FAIL ovf_err_early: err=%b want 0", err);
    else passes++;
    send_word(ws[4]);
    checks++;
    if ({mem_we, err} !== 2'b01) $display("FAIL ovf_w4: we,err=%b want 01", {mem_we, err});
    else passes++;
    send_trailer();
    wait_done("ovf");
    checks++;
    if (wcount - w0 !== 4) $display("FAIL ovf_wcount: writes=%0d want 4", wcount - w0);
    else passes++;
  endtask

  task automatic test_midframe_reset();
    int w0;
    w0 = wcount;
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'hAA); send_byte(8'hBB);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, mem_we, mem_sel, mem_addr, mem_wdata, cpu_hold, done, err} !==
        {1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0})
      $display("FAIL midrst_outs: got %h want %h",
               {in_ready, mem_we, mem_sel, mem_addr, mem_wdata, cpu_hold, done, err},
               {1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0});
    else passes++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (wcount != w0 || in_ready !== 1'b1 || cpu_hold !== 1'b1)
      $display("FAIL midrst_after: writes=%0d rdy=%b hold=%b want 0 1 1",
               wcount - w0, in_ready, cpu_hold);
    else passes++;
  endtask

`ifdef MEM_LOADER_CHKSUM_EN
  task automatic test_checksum();
    pulse_reset();
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
    send_word(32'h11223344);
    send_byte(8'h44);
    wait_done("chk_good");
    checks++;
    if (err !== 1'b0) $display("FAIL chk_good_err: err=%b want 0", err);
    else passes++;
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
    send_word(32'h11223344);
    send_byte(8'h45);
    wait_done("chk_bad");
    checks++;
    if ({err, done, cpu_hold} !== 3'b110)
      $display("FAIL chk_bad_flags: err,done,hold=%b want 110", {err, done, cpu_hold});
    else passes++;
  endtask
`endif

  initial begin
    test_reset();
    test_im_load();
    test_dm_stall();
    test_bad_target_empty();
    test_overflow();
    test_midframe_reset();
`ifdef MEM_LOADER_CHKSUM_EN
    test_checksum();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
